reg_busy_scoreboard: RTL and testbench
======================================

# reg_busy_scoreboard

Parametrised register-busy scoreboard for the in-order issue stage: an issue port sets a busy bit through an internal one-hot address decoder, and writeback ports clear busy bits through parallel decoders. Query ports report operand hazards. The block holds one registered busy bit per architectural register, a registered busy count, and a flush path. It sits between decode/issue (hazard stall) and writeback.

## Interface
Parameters:
- ADDR_W, 5, register index width; NUM_REGS = 2**ADDR_W (derived, not overridable)
- WB_PORTS, 2, number of writeback clear ports (1..4)
- RD_PORTS, 2, number of operand query ports (1..4)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- resetn  in  1  reset, synchronous and active-low
- flush  in  1  clears all busy bits at the next edge
- set_valid  in  1  issue requests marking set_addr busy
- set_addr  in  ADDR_W  destination register of the issuing instruction
- set_ready  out  1  combinational; the set can be accepted this cycle
- clr_valid  in  WB_PORTS  per-port writeback strobe
- clr_addr  in  WB_PORTS*ADDR_W  port i index at [i*ADDR_W +: ADDR_W]
- rd_addr  in  RD_PORTS*ADDR_W  port j query index, same packing
- rd_busy  out  RD_PORTS  combinational; queried register is busy
- busy_vec  out  NUM_REGS  registered busy bits; bit 0 is always 0
- busy_cnt  out  ADDR_W+1  registered population count of busy_vec

## Operation
- Set decode: one-hot of set_addr, gated by set_valid & set_ready. Clear decode: OR of the one-hots of the clr_addr[i] whose clr_valid[i] is high.
- Register 0 is never busy. A set to index 0 has set_ready=1 and is accepted with no state change. A clear of index 0 is ignored.
- next_busy = flush ? 0 : (busy_vec & ~clr_mask) | set_mask. A set takes priority over a clear of the same index in the same cycle.
- A clear of a non-busy register is a no-op, not an error. Duplicate clears across ports are harmless.
- set_ready = !busy_vec[set_addr] | (set_addr==0). With SCB_BYPASS_EN, it is also high when set_addr is being cleared this cycle. flush does not affect set_ready, but a set accepted in a flush cycle is discarded.
- rd_busy[j] = busy_vec[rd_addr[j]]. With SCB_BYPASS_EN, it is masked by clr_mask. set_mask is never forwarded to queries.
- busy_cnt is registered alongside busy_vec and equals popcount(next_busy). Its range is 0..NUM_REGS-1.

## Timing
- Reset (resetn=0 at an edge): busy_vec=0, busy_cnt=0. set_ready=1 and rd_busy=0 in the following cycle, regardless of inputs held during reset.
- Reset asserted mid-operation discards all pending busy state and pending sets on that edge.
- Set latency: an accepted set at edge N makes busy_vec[idx]=1 and rd_busy=1 (for a matching query) visible after edge N.
- Clear latency: a clear takes effect after the edge. With SCB_BYPASS_EN, rd_busy and set_ready see the clear in the same cycle, combinationally.
- Handshake: the issuer must hold set_valid/set_addr stable while set_ready=0. There is no internal queueing.
- flush has priority over set and clear. busy_vec=0 and busy_cnt=0 after the flush edge.

## Configuration
- SCB_BYPASS_EN defined: writeback clears are forwarded combinationally to rd_busy and set_ready. This removes a one-cycle stall after writeback, at the cost of a clr→rd_busy/set_ready combinational path.
- SCB_BYPASS_EN undefined: rd_busy and set_ready depend only on registered busy_vec. All combinational paths start from set_addr/rd_addr and the flops. Writeback is visible one cycle later.

## Test plan
- Reset, then set x5: busy_vec=32'h0000_0020 and busy_cnt=1 after the edge; rd_addr=5 gives rd_busy=1. Set x5 again: set_ready=0.
- With x5 and x7 busy, clr_valid=2'b11 on 5 and 7 in one cycle: busy_vec=0 and busy_cnt=0 next cycle. With SCB_BYPASS_EN, rd_busy for 5 is 0 in the clear cycle; without it, rd_busy is 1.
- With x9 busy, set x9 while clearing x9: with SCB_BYPASS_EN, set_ready=1 and x9 stays busy (busy_cnt unchanged). Without it, set_ready=0 and x9 is idle next cycle.
- Set x0 and clear x0: set_ready=1, busy_vec[0]=0, busy_cnt=0 throughout.
- Fill x1..x31 with 31 sets: busy_cnt=31. Then flush together with set x3: busy_vec=0 and busy_cnt=0 after the edge.
- Drive resetn=0 for one edge with 4 regs busy and set_valid=1: all outputs read reset values in the next cycle.

Source files
------------

// File: rtl/reg_busy_scoreboard.sv
// Register-busy scoreboard: issue sets, writeback clears, operand queries report hazards.
// Optional macro SCB_BYPASS_EN forwards same-cycle writeback clears to rd_busy and set_ready.
module reg_busy_scoreboard #(
    parameter int ADDR_W   = 5,
    parameter int WB_PORTS = 2,
    parameter int RD_PORTS = 2
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         flush,
    input  logic                         set_valid,
    input  logic [ADDR_W-1:0]            set_addr,
    output logic                         set_ready,
    input  logic [WB_PORTS-1:0]          clr_valid,
    input  logic [WB_PORTS*ADDR_W-1:0]   clr_addr,
    input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
    output logic [RD_PORTS-1:0]          rd_busy,
    output logic [(2**ADDR_W)-1:0]       busy_vec,
    output logic [ADDR_W:0]              busy_cnt
);
    localparam int NUM_REGS = 2**ADDR_W;

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic [NUM_REGS-1:0] clr_mask;
    logic [NUM_REGS-1:0] set_mask;

    // Clears from all writeback ports merge into one mask; register 0 is never tracked.
    always_comb begin
        clr_mask = '0;
        for (int i = 0; i < WB_PORTS; i++) begin
            if (clr_valid[i]) clr_mask[clr_addr[i*ADDR_W +: ADDR_W]] = 1'b1;
        end
        clr_mask[0] = 1'b0;
    end

    // Handshake: a set transfers on a cycle where set_valid && set_ready; the issuer
    // holds set_valid/set_addr stable while set_ready is low, nothing is queued here.
`ifdef SCB_BYPASS_EN
    assign set_ready = !busy_q[set_addr] || (set_addr == '0) || clr_mask[set_addr];
`else
    assign set_ready = !busy_q[set_addr] || (set_addr == '0);
`endif

    always_comb begin
        set_mask = '0;
        if (set_valid && set_ready) set_mask[set_addr] = 1'b1;
        set_mask[0] = 1'b0;
    end

    // Set is ORed in after the clear so it wins on a same-index collision.
    always_comb begin
        if (flush) busy_d = '0;
        else       busy_d = (busy_q & ~clr_mask) | set_mask;
        busy_d[0] = 1'b0;
        cnt_d = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt_d = cnt_d + {{ADDR_W{1'b0}}, busy_d[i]};
        end
    end

    always_comb begin
        rd_busy = '0;
        for (int j = 0; j < RD_PORTS; j++) begin
`ifdef SCB_BYPASS_EN
            rd_busy[j] = busy_q[rd_addr[j*ADDR_W +: ADDR_W]] &
                         !clr_mask[rd_addr[j*ADDR_W +: ADDR_W]];
`else
            rd_busy[j] = busy_q[rd_addr[j*ADDR_W +: ADDR_W]];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_vec = busy_q;
    assign busy_cnt = cnt_q;
endmodule

// File: tb/tb_reg_busy_scoreboard.sv
// Bench for reg_busy_scoreboard: directed steps then constrained-random traffic against
// an array-based model of the busy set; honours SCB_BYPASS_EN when it is defined.
module tb_reg_busy_scoreboard;
    localparam int ADDR_W   = 5;
    localparam int WB_PORTS = 2;
    localparam int RD_PORTS = 2;
    localparam int NUM_REGS = 2**ADDR_W;

    logic                       clk = 1'b0;
    logic                       resetn;
    logic                       flush;
    logic                       set_valid;
    logic [ADDR_W-1:0]          set_addr;
    logic                       set_ready;
    logic [WB_PORTS-1:0]        clr_valid;
    logic [WB_PORTS*ADDR_W-1:0] clr_addr;
    logic [RD_PORTS*ADDR_W-1:0] rd_addr;
    logic [RD_PORTS-1:0]        rd_busy;
    logic [NUM_REGS-1:0]        busy_vec;
    logic [ADDR_W:0]            busy_cnt;

    int total = 0;
    int bad   = 0;
    bit mdl [NUM_REGS];

`ifdef SCB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    always #5 clk = ~clk;

    reg_busy_scoreboard #(.ADDR_W(ADDR_W), .WB_PORTS(WB_PORTS), .RD_PORTS(RD_PORTS)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .set_valid(set_valid), .set_addr(set_addr), .set_ready(set_ready),
        .clr_valid(clr_valid), .clr_addr(clr_addr), .rd_addr(rd_addr),
        .rd_busy(rd_busy), .busy_vec(busy_vec), .busy_cnt(busy_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit being_cleared(input int a);
        bit hit = 1'b0;
        for (int i = 0; i < WB_PORTS; i++)
            if (clr_valid[i] && int'(clr_addr[i*ADDR_W +: ADDR_W]) == a && a != 0) hit = 1'b1;
        return hit;
    endfunction

    function automatic bit exp_ready();
        int a = int'(set_addr);
        return !mdl[a] || a == 0 || (BYP && being_cleared(a));
    endfunction

    function automatic logic [NUM_REGS-1:0] mdl_vec();
        logic [NUM_REGS-1:0] v = '0;
        for (int r = 0; r < NUM_REGS; r++) v[r] = mdl[r];
        return v;
    endfunction

    function automatic int mdl_count();
        int n = 0;
        for (int r = 0; r < NUM_REGS; r++) n += int'(mdl[r]);
        return n;
    endfunction

    task automatic idle();
        flush = 0; set_valid = 0; set_addr = '0; clr_valid = '0; clr_addr = '0;
    endtask

    task automatic set_rd(input int a0, input int a1);
        rd_addr = {ADDR_W'(a1), ADDR_W'(a0)};
    endtask

    task automatic set_clr(input int v, input int a0, input int a1);
        clr_valid = WB_PORTS'(v);
        clr_addr  = {ADDR_W'(a1), ADDR_W'(a0)};
    endtask

    // Check combinational outputs, advance one edge, update the model, check registers.
    task automatic cycle(input string tag);
        bit rdy;
        #1;
        rdy = exp_ready();
        check({tag, ".set_ready"}, 64'(set_ready), 64'(rdy));
        for (int j = 0; j < RD_PORTS; j++) begin
            int a = int'(rd_addr[j*ADDR_W +: ADDR_W]);
            check({tag, ".rd_busy"}, 64'(rd_busy[j]), 64'(mdl[a] && !(BYP && being_cleared(a))));
        end
        @(posedge clk);
        if (!resetn || flush) begin
            for (int r = 0; r < NUM_REGS; r++) mdl[r] = 1'b0;
        end else begin
            for (int i = 0; i < WB_PORTS; i++)
                if (clr_valid[i]) mdl[int'(clr_addr[i*ADDR_W +: ADDR_W])] = 1'b0;
            if (set_valid && rdy && set_addr != '0) mdl[int'(set_addr)] = 1'b1;
        end
        #1;
        check({tag, ".busy_vec"}, 64'(busy_vec), 64'(mdl_vec()));
        check({tag, ".busy_cnt"}, 64'(busy_cnt), 64'(mdl_count()));
    endtask

    initial begin
        bit hold;
        for (int r = 0; r < NUM_REGS; r++) mdl[r] = 1'b0;
        idle(); set_rd(5, 7);
        resetn = 0; set_valid = 1; set_addr = 5'd3;
        cycle("reset0");
        cycle("reset1");
        resetn = 1; idle();
        check("rst_vec", 64'(busy_vec), 64'h0);
        check("rst_cnt", 64'(busy_cnt), 64'h0);

        // set x5, query it, re-set is blocked
        set_valid = 1; set_addr = 5'd5;
        cycle("set5");
        check("set5_vec_const", 64'(busy_vec), 64'h20);
        check("set5_cnt_const", 64'(busy_cnt), 64'd1);
        #1 check("rd5_busy", 64'(rd_busy[0]), 64'd1);
        check("reset5_ready", 64'(set_ready), 64'd0);
        cycle("reset5_blocked");
        idle(); set_valid = 1; set_addr = 5'd7;
        cycle("set7");

        // dual clear of x5/x7
        idle(); set_clr(3, 5, 7);
        #1 check("clr_rd5", 64'(rd_busy[0]), BYP ? 64'd0 : 64'd1);
        cycle("clr57");
        check("clr57_cnt_const", 64'(busy_cnt), 64'd0);

        // set and clear x9 together
        idle(); set_valid = 1; set_addr = 5'd9; set_rd(9, 0);
        cycle("set9");
        set_clr(1, 9, 9);
        #1 check("setclr9_ready", 64'(set_ready), BYP ? 64'd1 : 64'd0);
        cycle("setclr9");
        check("setclr9_state", 64'(busy_vec[9]), BYP ? 64'd1 : 64'd0);
        idle(); set_clr(1, 9, 0);
        cycle("drain9");

        // register 0 is never busy
        idle(); set_valid = 1; set_addr = '0; set_clr(3, 0, 0); set_rd(0, 0);
        cycle("x0");
        check("x0_bit", 64'(busy_vec[0]), 64'd0);

        // fill x1..x31 then flush with a concurrent set
        idle();
        for (int r = 1; r < NUM_REGS; r++) begin
            set_valid = 1; set_addr = ADDR_W'(r);
            cycle("fill");
        end
        check("fill_cnt_const", 64'(busy_cnt), 64'd31);
        flush = 1; set_valid = 1; set_addr = 5'd3;
        cycle("flush");
        check("flush_cnt_const", 64'(busy_cnt), 64'd0);

        // reset mid-operation with 4 busy and a pending set
        idle();
        for (int r = 1; r <= 4; r++) begin
            set_valid = 1; set_addr = ADDR_W'(r * 6);
            cycle("pre_rst");
        end
        resetn = 0; set_valid = 1; set_addr = 5'd11;
        cycle("mid_rst");
        resetn = 1; idle(); set_rd(6, 12);
        cycle("post_rst");

        // random traffic, respecting hold-while-not-ready
        hold = 0;
        for (int n = 0; n < 400; n++) begin
            flush = ($urandom_range(0, 39) == 0);
            resetn = ($urandom_range(0, 99) != 0);
            if (!hold) begin
                set_valid = ($urandom_range(0, 3) != 0);
                set_addr  = ADDR_W'($urandom_range(0, NUM_REGS - 1));
            end
            set_clr(int'($urandom_range(0, 3)), int'($urandom_range(0, NUM_REGS - 1)),
                    int'($urandom_range(0, NUM_REGS - 1)));
            set_rd(int'($urandom_range(0, NUM_REGS - 1)), int'(set_addr));
            #1 hold = set_valid && !exp_ready();
            cycle("rand");
        end
        idle(); resetn = 1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
